// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder, D bits per cycle, LSB digit first.
// Optional subtract mode (op_sub port) enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int N = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] augend,
  input  logic [N-1:0] addend,
  input  logic         carry_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         op_sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [N:0]   final_sum
);

  localparam int DIGITS = N / D;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic          carry_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  acc_q;
  logic [N:0]    final_sum_q;
  logic          busy_q;
  logic          done_q;

  logic [D-1:0]  a_dig;
  logic [D-1:0]  b_dig;
  logic [D:0]    dsum;
  logic [N-1:0]  acc_d;
  logic          last_dig;
  logic [N-1:0]  b_load;
  logic          c_load;

  // Subtraction folds into the add path: invert addend, force carry-in of 1.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = op_sub ? ~addend : addend;
  assign c_load = op_sub ? 1'b1 : carry_in;
`else
  assign b_load = addend;
  assign c_load = carry_in;
`endif

  assign last_dig = (cnt_q == CW'(DIGITS - 1));

  always_comb begin
    int lsb;
    lsb   = int'(cnt_q) * D;
    a_dig = a_q[lsb +: D];
    b_dig = b_q[lsb +: D];
    dsum  = {1'b0, a_dig} + {1'b0, b_dig} + {{D{1'b0}}, carry_q};
    acc_d = acc_q;
    acc_d[lsb +: D] = dsum[D-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      final_sum_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= augend;
            b_q     <= b_load;
            carry_q <= c_load;
            cnt_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          carry_q <= dsum[D];
          cnt_q   <= cnt_q + CW'(1);
          if (last_dig) begin
            final_sum_q <= {dsum[D], acc_d};
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign final_sum = final_sum_q;

endmodule
